alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  Reservation station for integer/branch/JALR ops, directly upstream of the ALU.
//  Buffers issued ops until both operands are known, wakes entries from CDB broadcasts
//  (ALU and LSB results), dispatches one ready op per cycle to the ALU over registered outputs.
// PARAMETERS
//  RS_SIZE    8  number of entries (power of two, >=2)
//  ROB_IDX_W  4  ROB tag width; must equal ALU dest width
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous reset, active-low
//  rdy            in   1   global enable; 0 = stall
//  rob_clear      in   1   mispredict flush
//  issue_valid    in   1   decoder writes one op this cycle
//  issue_op_type  in   6   op code (same encoding the ALU decodes, 1..37)
//  issue_vj/vk    in   32  operand values (valid when matching q*_busy=0)
//  issue_qj/qk    in   4   producing ROB tag when operand not ready
//  issue_qj_busy  in   1   1 = vj pending on qj (same for qk_busy/qk)
//  issue_qk_busy  in   1
//  issue_dest     in   4   ROB tag of this op
//  rs_full        out  1   no free entry (combinational from occupancy)
//  cdb_alu_valid/cdb_alu_dest/cdb_alu_val  in 1/4/32  ALU broadcast
//  cdb_lsb_valid/cdb_lsb_dest/cdb_lsb_val  in 1/4/32  load broadcast
//  alu_mission    out  1   registered: op valid to ALU
//  alu_op_type    out  6   registered
//  alu_rs1/alu_rs2 out 32  registered operand values
//  alu_rob_dest   out  4   registered ROB tag
// BEHAVIOUR
//  - Reset (rst=0 at edge): all entry valid bits 0, all outputs 0; overrides everything.
//  - Priority per edge: rst > rob_clear > rdy=0 > normal. rob_clear: all entries invalid,
//    alu_mission<=0, same-cycle issue dropped. rdy=0: entries frozen, no issue/wakeup/dispatch,
//    alu_mission<=0, other outputs hold.
//  - Entry: valid, op, vj, qj, jbusy, vk, qk, kbusy, dest. Ready = valid & !jbusy & !kbusy.
//  - Issue: if issue_valid & !rs_full, write lowest-index free entry. Issue while rs_full
//    is ignored (upstream must not do it). Freed-this-edge slots are not reused same edge.
//  - Issue bypass: if issue_qj_busy and (cdb_alu_valid & cdb_alu_dest==issue_qj) or the LSB
//    equivalent, store value with jbusy=0; same for k. ALU checked before LSB if both match.
//  - Wakeup: every valid entry with jbusy & matching CDB tag captures value, clears jbusy
//    (same for k); both buses may wake different operands of one entry in the same edge.
//  - Dispatch: each edge, lowest-index ready entry (state before this edge's wakeup) is
//    copied to outputs, alu_mission<=1, entry freed. None ready: alu_mission<=0, data outputs
//    hold. Woken entry dispatches no earlier than following edge.
//  - Latency: issue_valid in cycle t with ready operands -> alu_mission high in cycle t+2.
//    Broadcast in cycle t waking last operand -> alu_mission in cycle t+2.
//  - rs_full = (valid count == RS_SIZE); a dispatch the same edge does not clear it early.
//  - Width: op/vals/tags passed unmodified; no arithmetic beyond tag compare.
// TESTING
//  1 Reset: rst=0 two cycles with issue_valid=1 -> alu_mission=0, rs_full=0, all outputs 0.
//  2 Ready issue: op=28(ADD), vj=5, vk=7, busy=0, dest=3 at t -> t+2 alu_mission=1,
//    rs1=5, rs2=7, alu_rob_dest=3; t+3 alu_mission=0.
//  3 Wakeup: issue op=29, qj=6 busy, vk=1; t+3 cdb_lsb_valid dest=6 val=0x10 ->
//    t+5 rs1=0x10, rs2=1; same-cycle bypass (CDB tag 6 at issue) -> dispatch at t+2.
//  4 Full: 8 issues of entries blocked on tag 9 -> rs_full=1; 9th issue ignored; broadcast
//    tag 9 -> dispatch order entries 0..7 over 8 consecutive cycles, rs_full drops 1 later.
//  5 Flush: 3 pending entries + issue_valid with rob_clear=1 -> next cycle rs_full=0,
//    alu_mission=0, later broadcasts cause no dispatch.
//  6 Stall: ready entry with rdy=0 for 3 cycles -> alu_mission=0 throughout; rdy=1 -> dispatch.

Source files
------------

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs : reservation station feeding the integer ALU.
//
// Holds issued integer/branch/JALR ops until both operands are available,
// captures operand values from the ALU and LSB result broadcasts, and sends
// the lowest-index ready op to the ALU each cycle over registered outputs.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   rdy                 global enable (0 = stall, alu_mission forced low)
//   rob_clear           mispredict flush: empties the station
//   issue_*             one op from the decoder per cycle
//   rs_full             no free entry (combinational from occupancy)
//   cdb_alu_*/cdb_lsb_* result broadcasts used for wakeup and issue bypass
//   alu_mission         registered: op presented to the ALU this cycle
//   alu_op_type/alu_rs1/alu_rs2/alu_rob_dest  registered op payload
// ---------------------------------------------------------------------------
module alu_rs #(
   parameter int RS_SIZE   = 8,
   parameter int ROB_IDX_W = 4,
   parameter int DATA_W    = 32,
   parameter int OP_W      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rob_clear,
   input  logic                 issue_valid,
   input  logic [OP_W-1:0]      issue_op_type,
   input  logic [DATA_W-1:0]    issue_vj,
   input  logic [DATA_W-1:0]    issue_vk,
   input  logic [ROB_IDX_W-1:0] issue_qj,
   input  logic [ROB_IDX_W-1:0] issue_qk,
   input  logic                 issue_qj_busy,
   input  logic                 issue_qk_busy,
   input  logic [ROB_IDX_W-1:0] issue_dest,
   output logic                 rs_full,
   input  logic                 cdb_alu_valid,
   input  logic [ROB_IDX_W-1:0] cdb_alu_dest,
   input  logic [DATA_W-1:0]    cdb_alu_val,
   input  logic                 cdb_lsb_valid,
   input  logic [ROB_IDX_W-1:0] cdb_lsb_dest,
   input  logic [DATA_W-1:0]    cdb_lsb_val,
   output logic                 alu_mission,
   output logic [OP_W-1:0]      alu_op_type,
   output logic [DATA_W-1:0]    alu_rs1,
   output logic [DATA_W-1:0]    alu_rs2,
   output logic [ROB_IDX_W-1:0] alu_rob_dest
);

   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0]   ent_valid;
   logic [RS_SIZE-1:0]   ent_jbusy;
   logic [RS_SIZE-1:0]   ent_kbusy;
   logic [OP_W-1:0]      ent_op   [RS_SIZE];
   logic [DATA_W-1:0]    ent_vj   [RS_SIZE];
   logic [DATA_W-1:0]    ent_vk   [RS_SIZE];
   logic [ROB_IDX_W-1:0] ent_qj   [RS_SIZE];
   logic [ROB_IDX_W-1:0] ent_qk   [RS_SIZE];
   logic [ROB_IDX_W-1:0] ent_dest [RS_SIZE];

   logic [RS_SIZE-1:0]   ent_ready;
   logic [IDX_W-1:0]     free_idx;
   logic [IDX_W-1:0]     disp_idx;
   logic                 disp_found;
   logic                 iss_take;
   logic                 advance;

   logic                 iss_j_alu, iss_j_lsb, iss_k_alu, iss_k_lsb;
   logic                 iss_jbusy, iss_kbusy;
   logic [DATA_W-1:0]    iss_vj, iss_vk;

   // Stage p0: select free slot and dispatch candidate from current entry state
   assign ent_ready = ent_valid & ~ent_jbusy & ~ent_kbusy;
   assign rs_full   = &ent_valid;
   assign advance   = rst & ~rob_clear & rdy;
   assign iss_take  = issue_valid & ~rs_full;

   // Descending scan so the lowest matching index is the last one written.
   always_comb begin
      free_idx   = '0;
      disp_idx   = '0;
      disp_found = 1'b0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!ent_valid[i]) begin
            free_idx = IDX_W'(i);
         end
         if (ent_ready[i]) begin
            disp_idx   = IDX_W'(i);
            disp_found = 1'b1;
         end
      end
   end

   // A broadcast in the issue cycle would otherwise be missed, so the new
   // entry captures it directly; the ALU bus wins if both buses carry the tag.
   assign iss_j_alu = issue_qj_busy & cdb_alu_valid & (cdb_alu_dest == issue_qj);
   assign iss_j_lsb = issue_qj_busy & cdb_lsb_valid & (cdb_lsb_dest == issue_qj);
   assign iss_k_alu = issue_qk_busy & cdb_alu_valid & (cdb_alu_dest == issue_qk);
   assign iss_k_lsb = issue_qk_busy & cdb_lsb_valid & (cdb_lsb_dest == issue_qk);
   assign iss_jbusy = issue_qj_busy & ~iss_j_alu & ~iss_j_lsb;
   assign iss_kbusy = issue_qk_busy & ~iss_k_alu & ~iss_k_lsb;
   assign iss_vj    = iss_j_alu ? cdb_alu_val : (iss_j_lsb ? cdb_lsb_val : issue_vj);
   assign iss_vk    = iss_k_alu ? cdb_alu_val : (iss_k_lsb ? cdb_lsb_val : issue_vk);

   // Stage p1: entry payload (wakeup and issue write); occupancy lives in ent_valid
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_valid[i] && ent_jbusy[i]) begin
               if (cdb_alu_valid && cdb_alu_dest == ent_qj[i]) begin
                  ent_vj[i]    <= cdb_alu_val;
                  ent_jbusy[i] <= 1'b0;
               end else if (cdb_lsb_valid && cdb_lsb_dest == ent_qj[i]) begin
                  ent_vj[i]    <= cdb_lsb_val;
                  ent_jbusy[i] <= 1'b0;
               end
            end
            if (ent_valid[i] && ent_kbusy[i]) begin
               if (cdb_alu_valid && cdb_alu_dest == ent_qk[i]) begin
                  ent_vk[i]    <= cdb_alu_val;
                  ent_kbusy[i] <= 1'b0;
               end else if (cdb_lsb_valid && cdb_lsb_dest == ent_qk[i]) begin
                  ent_vk[i]    <= cdb_lsb_val;
                  ent_kbusy[i] <= 1'b0;
               end
            end
         end
         // free_idx is never a valid entry, so this never collides with wakeup.
         if (iss_take) begin
            ent_op[free_idx]    <= issue_op_type;
            ent_vj[free_idx]    <= iss_vj;
            ent_vk[free_idx]    <= iss_vk;
            ent_qj[free_idx]    <= issue_qj;
            ent_qk[free_idx]    <= issue_qk;
            ent_jbusy[free_idx] <= iss_jbusy;
            ent_kbusy[free_idx] <= iss_kbusy;
            ent_dest[free_idx]  <= issue_dest;
         end
      end
   end

   // Stage p1: occupancy and registered dispatch to the ALU
   always_ff @(posedge clk) begin
      if (!rst) begin
         ent_valid    <= '0;
         alu_mission  <= 1'b0;
         alu_op_type  <= '0;
         alu_rs1      <= '0;
         alu_rs2      <= '0;
         alu_rob_dest <= '0;
      end else if (rob_clear) begin
         ent_valid   <= '0;
         alu_mission <= 1'b0;
      end else if (!rdy) begin
         alu_mission <= 1'b0;
      end else begin
         alu_mission <= disp_found;
         if (disp_found) begin
            alu_op_type         <= ent_op[disp_idx];
            alu_rs1             <= ent_vj[disp_idx];
            alu_rs2             <= ent_vk[disp_idx];
            alu_rob_dest        <= ent_dest[disp_idx];
            ent_valid[disp_idx] <= 1'b0;
         end
         // Slot freed by this dispatch is still counted occupied here, so
         // free_idx can never equal disp_idx.
         if (iss_take) begin
            ent_valid[free_idx] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;

   logic        clk = 1'b0;
   logic        rst, rdy, rob_clear, issue_valid;
   logic [5:0]  issue_op_type;
   logic [31:0] issue_vj, issue_vk;
   logic [3:0]  issue_qj, issue_qk, issue_dest;
   logic        issue_qj_busy, issue_qk_busy;
   logic        rs_full;
   logic        cdb_alu_valid, cdb_lsb_valid;
   logic [3:0]  cdb_alu_dest, cdb_lsb_dest;
   logic [31:0] cdb_alu_val, cdb_lsb_val;
   logic        alu_mission;
   logic [5:0]  alu_op_type;
   logic [31:0] alu_rs1, alu_rs2;
   logic [3:0]  alu_rob_dest;

   int n_chk  = 0;
   int n_fail = 0;

   alu_rs dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
      .issue_valid(issue_valid), .issue_op_type(issue_op_type),
      .issue_vj(issue_vj), .issue_vk(issue_vk),
      .issue_qj(issue_qj), .issue_qk(issue_qk),
      .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
      .issue_dest(issue_dest), .rs_full(rs_full),
      .cdb_alu_valid(cdb_alu_valid), .cdb_alu_dest(cdb_alu_dest), .cdb_alu_val(cdb_alu_val),
      .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_dest(cdb_lsb_dest), .cdb_lsb_val(cdb_lsb_val),
      .alu_mission(alu_mission), .alu_op_type(alu_op_type),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rob_dest(alu_rob_dest)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (slot array, spec-level rules) -------
   typedef struct {
      logic        v;
      logic [5:0]  op;
      logic [31:0] vj, vk;
      logic [3:0]  qj, qk;
      logic        jb, kb;
      logic [3:0]  dest;
   } ent_t;

   ent_t        m [8];
   logic        m_mis;
   logic [5:0]  m_op;
   logic [31:0] m_rs1, m_rs2;
   logic [3:0]  m_dest;

   // Returns {still_waiting, value} for an operand after looking at both buses.
   function automatic logic [32:0] resolve(input logic busy, input logic [3:0] q,
                                           input logic [31:0] v);
      if (!busy) return {1'b0, v};
      if (cdb_alu_valid && cdb_alu_dest == q) return {1'b0, cdb_alu_val};
      if (cdb_lsb_valid && cdb_lsb_dest == q) return {1'b0, cdb_lsb_val};
      return {1'b1, v};
   endfunction

   function automatic logic model_full();
      for (int i = 0; i < 8; i++) if (!m[i].v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      ent_t nxt [8];
      int d = -1;
      int f = -1;
      logic [32:0] r;
      if (!rst) begin
         for (int i = 0; i < 8; i++) m[i].v = 1'b0;
         m_mis = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_dest = 0;
         return;
      end
      if (rob_clear) begin
         for (int i = 0; i < 8; i++) m[i].v = 1'b0;
         m_mis = 0;
         return;
      end
      if (!rdy) begin
         m_mis = 0;
         return;
      end
      nxt = m;
      for (int i = 0; i < 8; i++) begin
         if (d < 0 && m[i].v && !m[i].jb && !m[i].kb) d = i;
         if (f < 0 && !m[i].v) f = i;
      end
      for (int i = 0; i < 8; i++) begin
         if (m[i].v) begin
            r = resolve(m[i].jb, m[i].qj, m[i].vj); nxt[i].jb = r[32]; nxt[i].vj = r[31:0];
            r = resolve(m[i].kb, m[i].qk, m[i].vk); nxt[i].kb = r[32]; nxt[i].vk = r[31:0];
         end
      end
      if (d >= 0) begin
         m_mis = 1; m_op = m[d].op; m_rs1 = m[d].vj; m_rs2 = m[d].vk; m_dest = m[d].dest;
         nxt[d].v = 1'b0;
      end else begin
         m_mis = 0;
      end
      if (issue_valid && f >= 0) begin
         nxt[f].v = 1'b1; nxt[f].op = issue_op_type; nxt[f].dest = issue_dest;
         nxt[f].qj = issue_qj; nxt[f].qk = issue_qk;
         r = resolve(issue_qj_busy, issue_qj, issue_vj); nxt[f].jb = r[32]; nxt[f].vj = r[31:0];
         r = resolve(issue_qk_busy, issue_qk, issue_vk); nxt[f].kb = r[32]; nxt[f].vk = r[31:0];
      end
      m = nxt;
   endtask

   // ---------------- stimulus helpers --------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rst = 1; rdy = 1; rob_clear = 0; issue_valid = 0;
      issue_op_type = 0; issue_vj = 0; issue_vk = 0; issue_qj = 0; issue_qk = 0;
      issue_qj_busy = 0; issue_qk_busy = 0; issue_dest = 0;
      cdb_alu_valid = 0; cdb_alu_dest = 0; cdb_alu_val = 0;
      cdb_lsb_valid = 0; cdb_lsb_dest = 0; cdb_lsb_val = 0;
   endtask

   task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [3:0] qj, input logic jb, input logic [3:0] qk,
                            input logic kb, input logic [3:0] dest);
      issue_valid = 1; issue_op_type = op; issue_vj = vj; issue_vk = vk;
      issue_qj = qj; issue_qj_busy = jb; issue_qk = qk; issue_qk_busy = kb; issue_dest = dest;
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      drive_idle();
      rst = 0;
      set_issue(6'd28, 32'h1, 32'h2, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1);
      cyc(); cyc();
      n_chk++; if (alu_mission !== 1'b0) begin n_fail++; $display("FAIL reset_mission: got %b want 0", alu_mission); end
      n_chk++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_rs_full: got %b want 0", rs_full); end
      n_chk++; if ({alu_op_type, alu_rs1, alu_rs2, alu_rob_dest} !== 74'd0) begin
         n_fail++; $display("FAIL reset_outputs: got op=%0d rs1=%h rs2=%h dest=%0d want all 0",
                            alu_op_type, alu_rs1, alu_rs2, alu_rob_dest); end
      drive_idle();
      cyc();
      n_chk++; if (alu_mission !== 1'b0) begin n_fail++; $display("FAIL reset_release_mission: got %b want 0", alu_mission); end
   endtask

   task automatic test_ready_issue();
      set_issue(6'd28, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
      cyc();
      issue_valid = 0;
      n_chk++; if (alu_mission !== 1'b0) begin n_fail++; $display("FAIL ready_t1: got %b want 0", alu_mission); end
      cyc();
      n_chk++; if ({alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest} !== {1'b1, 6'd28, 32'd5, 32'd7, 4'd3}) begin
         n_fail++; $display("FAIL ready_t2: got mis=%b op=%0d rs1=%0d rs2=%0d dest=%0d want 1/28/5/7/3",
                            alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest); end
      cyc();
      n_chk++; if ({alu_mission, alu_rs1, alu_rob_dest} !== {1'b0, 32'd5, 4'd3}) begin
         n_fail++; $display("FAIL ready_t3: got mis=%b rs1=%0d dest=%0d want 0/5/3 (hold)",
                            alu_mission, alu_rs1, alu_rob_dest); end
   endtask

   task automatic test_wakeup();
      set_issue(6'd29, 32'hdead, 32'd1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd4);
      cyc(); issue_valid = 0;
      cyc();
      cyc();
      n_chk++; if (alu_mission !== 1'b0) begin n_fail++; $display("FAIL wake_early: got %b want 0", alu_mission); end
      cdb_lsb_valid = 1; cdb_lsb_dest = 4'd6; cdb_lsb_val = 32'h10;
      cyc();
      cdb_lsb_valid = 0;
      n_chk++; if (alu_mission !== 1'b0) begin n_fail++; $display("FAIL wake_t4: got %b want 0", alu_mission); end
      cyc();
      n_chk++; if ({alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest} !== {1'b1, 6'd29, 32'h10, 32'd1, 4'd4}) begin
         n_fail++; $display("FAIL wake_t5: got mis=%b op=%0d rs1=%h rs2=%h dest=%0d want 1/29/10/1/4",
                            alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest); end
      // Bypass: tag on both buses in the issue cycle, ALU value must win.
      set_issue(6'd29, 32'hdead, 32'd2, 4'd6, 1'b1, 4'd0, 1'b0, 4'd5);
      cdb_alu_valid = 1; cdb_alu_dest = 4'd6; cdb_alu_val = 32'h55;
      cdb_lsb_valid = 1; cdb_lsb_dest = 4'd6; cdb_lsb_val = 32'h66;
      cyc();
      drive_idle();
      cyc();
      n_chk++; if ({alu_mission, alu_rs1, alu_rs2, alu_rob_dest} !== {1'b1, 32'h55, 32'd2, 4'd5}) begin
         n_fail++; $display("FAIL bypass: got mis=%b rs1=%h rs2=%h dest=%0d want 1/55/2/5",
                            alu_mission, alu_rs1, alu_rs2, alu_rob_dest); end
      cyc();
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         set_issue(6'd28, 32'd0, 32'(i), 4'd9, 1'b1, 4'd0, 1'b0, 4'(i));
         cyc();
      end
      n_chk++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", rs_full); end
      set_issue(6'd30, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15);
      cyc();
      issue_valid = 0;
      n_chk++; if ({rs_full, alu_mission} !== 2'b10) begin
         n_fail++; $display("FAIL full_ninth: got full=%b mis=%b want 1/0", rs_full, alu_mission); end
      cdb_alu_valid = 1; cdb_alu_dest = 4'd9; cdb_alu_val = 32'h90;
      cyc();
      cdb_alu_valid = 0;
      n_chk++; if ({rs_full, alu_mission} !== 2'b10) begin
         n_fail++; $display("FAIL full_wake_edge: got full=%b mis=%b want 1/0", rs_full, alu_mission); end
      for (int k = 0; k < 8; k++) begin
         cyc();
         n_chk++; if ({alu_mission, alu_rs1, alu_rs2, alu_rob_dest, rs_full} !== {1'b1, 32'h90, 32'(k), 4'(k), 1'b0}) begin
            n_fail++; $display("FAIL full_drain_%0d: got mis=%b rs1=%h rs2=%0d dest=%0d full=%b want 1/90/%0d/%0d/0",
                               k, alu_mission, alu_rs1, alu_rs2, alu_rob_dest, rs_full, k, k); end
      end
      cyc();
      n_chk++; if (alu_mission !== 1'b0) begin n_fail++; $display("FAIL full_after: got %b want 0", alu_mission); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         set_issue(6'd28, 32'd0, 32'd3, 4'd11, 1'b1, 4'd0, 1'b0, 4'(i + 8));
         cyc();
      end
      set_issue(6'd28, 32'd4, 32'd4, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12);
      rob_clear = 1;
      cyc();
      drive_idle();
      n_chk++; if ({rs_full, alu_mission} !== 2'b00) begin
         n_fail++; $display("FAIL flush_state: got full=%b mis=%b want 0/0", rs_full, alu_mission); end
      cdb_alu_valid = 1; cdb_alu_dest = 4'd11; cdb_alu_val = 32'h77;
      cyc();
      cdb_alu_valid = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         n_chk++; if (alu_mission !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_dispatch_%0d: got %b want 0 (dest=%0d)", k, alu_mission, alu_rob_dest); end
      end
   endtask

   task automatic test_stall();
      set_issue(6'd30, 32'h11, 32'h22, 4'd0, 1'b0, 4'd0, 1'b0, 4'd13);
      cyc();
      set_issue(6'd31, 32'h33, 32'h44, 4'd0, 1'b0, 4'd0, 1'b0, 4'd14);
      rdy = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         issue_valid = 0;
         n_chk++; if ({alu_mission, alu_rob_dest} !== {1'b0, 4'd7}) begin
            n_fail++; $display("FAIL stall_%0d: got mis=%b dest=%0d want 0/7 (hold)", k, alu_mission, alu_rob_dest); end
      end
      rdy = 1;
      cyc();
      n_chk++; if ({alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest} !== {1'b1, 6'd30, 32'h11, 32'h22, 4'd13}) begin
         n_fail++; $display("FAIL stall_release: got mis=%b op=%0d rs1=%h rs2=%h dest=%0d want 1/30/11/22/13",
                            alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest); end
      cyc();
      n_chk++; if (alu_mission !== 1'b0) begin
         n_fail++; $display("FAIL stall_issue_dropped: got mis=%b dest=%0d want 0", alu_mission, alu_rob_dest); end
   endtask

   task automatic test_random();
      drive_idle();
      rst = 0;
      model_edge();
      cyc();
      rst = 1;
      for (int c = 0; c < 1500; c++) begin
         rdy           = ($urandom_range(0, 9) != 0);
         rob_clear     = ($urandom_range(0, 59) == 0);
         issue_valid   = !model_full() && ($urandom_range(0, 2) != 0);
         issue_op_type = 6'($urandom_range(1, 37));
         issue_vj      = $urandom;
         issue_vk      = $urandom;
         issue_qj      = 4'($urandom_range(0, 7));
         issue_qk      = 4'($urandom_range(0, 7));
         issue_qj_busy = 1'($urandom_range(0, 1));
         issue_qk_busy = 1'($urandom_range(0, 1));
         issue_dest    = 4'($urandom_range(0, 15));
         cdb_alu_valid = ($urandom_range(0, 2) == 0);
         cdb_alu_dest  = 4'($urandom_range(0, 7));
         cdb_alu_val   = $urandom;
         cdb_lsb_valid = ($urandom_range(0, 2) == 0);
         cdb_lsb_dest  = 4'($urandom_range(0, 7));
         cdb_lsb_val   = $urandom;
         model_edge();
         cyc();
         n_chk++; if (alu_mission !== m_mis) begin n_fail++; $display("FAIL rand_mission c=%0d: got %b want %b", c, alu_mission, m_mis); end
         n_chk++; if (alu_op_type !== m_op) begin n_fail++; $display("FAIL rand_op c=%0d: got %0d want %0d", c, alu_op_type, m_op); end
         n_chk++; if (alu_rs1 !== m_rs1) begin n_fail++; $display("FAIL rand_rs1 c=%0d: got %h want %h", c, alu_rs1, m_rs1); end
         n_chk++; if (alu_rs2 !== m_rs2) begin n_fail++; $display("FAIL rand_rs2 c=%0d: got %h want %h", c, alu_rs2, m_rs2); end
         n_chk++; if (alu_rob_dest !== m_dest) begin n_fail++; $display("FAIL rand_dest c=%0d: got %0d want %0d", c, alu_rob_dest, m_dest); end
         n_chk++; if (rs_full !== model_full()) begin n_fail++; $display("FAIL rand_full c=%0d: got %b want %b", c, rs_full, model_full()); end
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      @(negedge clk);
      test_reset();
      test_ready_issue();
      test_wakeup();
      test_full();
      test_flush();
      test_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
